clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- NUM_CH-channel integer clock divider; all channels run from one reference clock. Each channel has its own enable and ratio.
- Improvements over the single-channel divider:
  - Ratio changes are glitch-free: a new ratio loads only at a period boundary.
  - Duty cycle is defined for both odd and even ratios.
  - A one-cycle tick is output at each divided period start.
  - A common sync input phase-aligns all running channels.
- Feeds the UART/peripheral clock domains; sits beside the reset synchronisers in the clock/reset group.

Parameters:
- DIV_RATIO_WIDTH, 8, width of each channel's ratio field and counter.
- NUM_CH, 2, number of independent divider channels (1..16).

Ports:
- i_ref_clk  in  1  reference clock; the only clock in the block.
- i_rst  in  1  asynchronous active-high reset.
- i_clk_en  in  NUM_CH  per-channel enable; bit ch controls channel ch.
- i_div_ratio  in  NUM_CH*DIV_RATIO_WIDTH  packed ratios; channel ch uses bits [ch*W +: W], where W = DIV_RATIO_WIDTH.
- i_sync  in  1  single-cycle pulse that restarts the period of every running channel.
- o_div_clk  out  NUM_CH  divided clocks.
- o_div_tick  out  NUM_CH  registered pulse, 1 cycle wide, in the i_ref_clk cycle where a period starts.

Behaviour:
- Interface: one clock, i_ref_clk; reset i_rst is asynchronous, active-high.
- Registered state per channel:
  - state: IDLE or RUN
  - r_act: active ratio, W bits
  - cnt: W bits
  - div_q: 1 bit
  - tick_q: 1 bit
- Reset (asynchronous, immediate, including mid-period): state=IDLE, r_act=0, cnt=0, div_q=0, tick_q=0. Result: o_div_clk=0 and o_div_tick=0.
- Derived values:
  - H = (r_act+1)>>1, computed at W+1 bits so that r_act = 2^W-1 does not overflow.
  - bypass = (state==RUN) && (r_act<2).
  - end_of_period = (r_act<2) || (cnt == r_act-1) || i_sync.
- Period-start action (PS), on one edge:
  - cnt<=0
  - r_act<=new ratio from i_div_ratio
  - div_q<=1 if new ratio>=2, else 0
  - tick_q<=1
- IDLE state:
  - div_q<=0, tick_q<=0, cnt<=0, r_act<=i_div_ratio every edge.
  - If i_clk_en[ch]=1: perform PS and go to RUN.
  - Ratio is latched on the enabling edge, so the first divided cycle starts high on the following edge.
- RUN state:
  - If i_clk_en[ch]=0: go to IDLE with div_q<=0, tick_q<=0, cnt<=0. The output drops low on the next edge; no runt high pulse beyond that cycle.
  - Else if end_of_period: perform PS.
  - Else: cnt<=cnt+1, div_q<=((cnt+1)<H), tick_q<=0.
- Waveform: a period is exactly r_act cycles, high for ceil(N/2) cycles, then low for floor(N/2) cycles (N = r_act).
  - N=3: 110
  - N=4: 1100
  - N=5: 11100
- Ratio change mid-period: the value on i_div_ratio is ignored until the PS edge, so no truncated or stretched half-period.
- Bypass (RUN, r_act 0 or 1):
  - o_div_clk = i_ref_clk through a combinational mux; the select comes only from registers.
  - tick_q=1 every cycle; r_act reloads every edge, so leaving bypass takes effect on the next edge.
- Otherwise o_div_clk = div_q; o_div_tick = tick_q.
- i_sync:
  - Forces PS on every RUN channel on the same edge, so all of them rise together one cycle later.
  - IDLE channels ignore it.
  - Sync coinciding with a natural period end: a single PS, no double tick.
  - Sync coinciding with an enable drop: the disable wins.
- Channels are fully independent except for the shared i_sync.
- No combinational path from inputs to o_div_tick.

Test Plan:
- Ratio=4 on ch0, en rises at edge E:
  - o_div_clk = 1,1,0,0 repeating from E+1.
  - o_div_tick high at E+1, E+5, E+9, …
- Ratio=5 on ch1: 1,1,1,0,0 repeating; period exactly 5 cycles over 100 periods; tick every 5 cycles.
- Ratio change under load:
  - Stimulus: ch0 at ratio 6; change i_div_ratio to 3 at cnt=1.
  - Required: the current period completes as 111000; the next period is 110; no glitch.
- Bypass:
  - Ratio=1 with en=1: o_div_clk equals i_ref_clk and o_div_tick is constant 1.
  - Switching ratio to 2: next edge starts 1,0 pattern.
  - Ratio=0 behaves identically to ratio=1.
- Sync alignment:
  - Stimulus: ch0 ratio 4, ch1 ratio 6, running out of phase; pulse i_sync.
  - Required: both channels' ticks assert on the same edge and both outputs rise together.
  - Required: an IDLE ch stays 0.
- Enable and reset:
  - Disable mid-high: o_div_clk is 0 after the next edge.
  - Re-enable: restarts at cnt 0.
  - Asserting i_rst mid-period clears all outputs immediately without waiting for a clock edge.

Source files
------------

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel integer clock divider. Every channel runs from i_ref_clk and
//   divides it by its own ratio N. The output is high for ceil(N/2) cycles and
//   low for floor(N/2) cycles. A one-cycle tick marks the start of each period.
//   A new ratio is only taken at a period boundary, so a change never truncates
//   or stretches a half-period. Ratios 0 and 1 pass the reference clock
//   straight through.
//
// Ports
//   i_ref_clk    reference clock (only clock in the block)
//   i_rst        asynchronous active-high reset
//   i_clk_en     per-channel enable, bit ch controls channel ch
//   i_div_ratio  packed ratios, channel ch uses [ch*W +: W]
//   i_sync       single-cycle pulse restarting the period of all running channels
//   o_div_clk    divided clocks
//   o_div_tick   registered one-cycle pulse on the cycle a period starts
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int NUM_CH          = 2
) (
    input  logic                              i_ref_clk,
    input  logic                              i_rst,
    input  logic [NUM_CH-1:0]                 i_clk_en,
    input  logic [NUM_CH*DIV_RATIO_WIDTH-1:0] i_div_ratio,
    input  logic                              i_sync,
    output logic [NUM_CH-1:0]                 o_div_clk,
    output logic [NUM_CH-1:0]                 o_div_tick
);

    localparam int W = DIV_RATIO_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t         state_q, state_d;
        logic [W-1:0]   r_act_q, r_act_d;
        logic [W-1:0]   cnt_q, cnt_d;
        logic           div_q, div_d;
        logic           tick_q, tick_d;

        logic [W-1:0]   ratio_in;
        logic [W-1:0]   cnt_inc;
        logic [W:0]     half;
        logic           act_small;
        logic           new_hi;
        logic           bypass;
        logic           end_of_period;

        assign ratio_in  = i_div_ratio[ch*W +: W];
        assign cnt_inc   = cnt_q + W'(1);
        // One extra bit so that the largest ratio does not wrap when rounding up.
        assign half      = ({1'b0, r_act_q} + (W+1)'(1)) >> 1;
        assign act_small = ({1'b0, r_act_q} < (W+1)'(2));
        assign new_hi    = ({1'b0, ratio_in} >= (W+1)'(2));
        assign bypass    = (state_q == ST_RUN) && act_small;
        assign end_of_period = act_small || (cnt_q == (r_act_q - W'(1))) || i_sync;

        always_comb begin
            state_d = state_q;
            r_act_d = r_act_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            tick_d  = tick_q;
            case (state_q)
                ST_IDLE: begin
                    // Track the ratio input continuously so the enabling edge
                    // starts the first period with the ratio present then.
                    r_act_d = ratio_in;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                    tick_d  = 1'b0;
                    if (i_clk_en[ch]) begin
                        state_d = ST_RUN;
                        div_d   = new_hi;
                        tick_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_clk_en[ch]) begin
                        // Disable has priority over sync and period end.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        div_d   = 1'b0;
                        tick_d  = 1'b0;
                    end else if (end_of_period) begin
                        // Period start: the only point a new ratio is accepted.
                        cnt_d   = '0;
                        r_act_d = ratio_in;
                        div_d   = new_hi;
                        tick_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                        div_d   = ({1'b0, cnt_inc} < half);
                        tick_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge i_ref_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= ST_IDLE;
                r_act_q <= '0;
                cnt_q   <= '0;
                div_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                r_act_q <= r_act_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                tick_q  <= tick_d;
            end
        end

        // Mux select comes only from registers, so the bypass path is glitch-free
        // apart from the reference clock itself.
        assign o_div_clk[ch]  = bypass ? i_ref_clk : div_q;
        assign o_div_tick[ch] = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    localparam int W  = 8;
    localparam int NC = 3;

    logic            clk;
    logic            rst;
    logic [NC-1:0]   en;
    logic [NC*W-1:0] ratio;
    logic            sync;
    logic [NC-1:0]   div_clk;
    logic [NC-1:0]   div_tick;

    int total = 0;
    int bad   = 0;

    // Reference model: per channel, whether it is running, the period length
    // in force and the position inside the current period.
    int m_run [NC];
    int m_n   [NC];
    int m_pos [NC];

    logic [NC-1:0] pos_clk;
    logic [NC-1:0] pos_tick;

    clk_div_multi #(
        .DIV_RATIO_WIDTH (W),
        .NUM_CH          (NC)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .i_sync      (sync),
        .o_div_clk   (div_clk),
        .o_div_tick  (div_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_run[c] = 0;
            m_n[c]   = 0;
            m_pos[c] = 0;
        end
    endtask

    // Apply the divider rules for one reference edge using the current inputs.
    task automatic model_edge();
        for (int c = 0; c < NC; c++) begin
            int r;
            r = int'(ratio[c*W +: W]);
            if (m_run[c] == 0) begin
                if (en[c]) begin
                    m_run[c] = 1;
                    m_n[c]   = r;
                    m_pos[c] = 0;
                end
            end else if (!en[c]) begin
                m_run[c] = 0;
            end else if (m_n[c] < 2 || m_pos[c] == m_n[c] - 1 || sync) begin
                m_n[c]   = r;
                m_pos[c] = 0;
            end else begin
                m_pos[c] = m_pos[c] + 1;
            end
        end
    endtask

    task automatic check_all(input string where);
        for (int c = 0; c < NC; c++) begin
            logic ec, et;
            if (m_run[c] == 0) begin
                ec = 1'b0;
                et = 1'b0;
            end else if (m_n[c] < 2) begin
                ec = clk;
                et = 1'b1;
            end else begin
                ec = (m_pos[c] < (m_n[c] + 1) / 2);
                et = (m_pos[c] == 0);
            end
            total++;
            assert (div_clk[c] === ec) else begin
                bad++;
                $error("FAIL %s clk ch%0d: observed=%0b expected=%0b", where, c, div_clk[c], ec);
            end
            total++;
            assert (div_tick[c] === et) else begin
                bad++;
                $error("FAIL %s tick ch%0d: observed=%0b expected=%0b", where, c, div_tick[c], et);
            end
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One reference cycle: inputs are already stable; check after the rising
    // edge (reference high) and after the falling edge (reference low).
    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        pos_clk  = div_clk;
        pos_tick = div_tick;
        check_all(where);
        @(negedge clk);
        #1;
        check_all(where);
    endtask

    task automatic set_ratio(input int c, input int r);
        ratio[c*W +: W] = W'(r);
    endtask

    initial begin
        logic [8:0] pat9;
        logic [7:0] pc8, pt8;
        logic [3:0] pc4, pt4;
        int ticks, highs, gap_err, last;

        rst  = 1'b0;
        en   = '0;
        ratio = '0;
        sync = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b0;

        // Ratio 4 on ch0
        set_ratio(0, 4);
        en = 3'b001;
        for (int i = 0; i < 8; i++) begin
            step("r4");
            pc8[7-i] = pos_clk[0];
            pt8[7-i] = pos_tick[0];
        end
        expect_val("r4_clk_pattern", 32'(pc8), 32'h000000CC);
        expect_val("r4_tick_pattern", 32'(pt8), 32'h00000088);

        // Ratio 5 on ch1 over 100 periods
        set_ratio(1, 5);
        en = 3'b011;
        ticks = 0; highs = 0; gap_err = 0; last = -1;
        for (int i = 0; i < 500; i++) begin
            step("r5");
            if (pos_clk[1]) highs++;
            if (pos_tick[1]) begin
                if (last >= 0 && i - last != 5) gap_err++;
                last = i;
                ticks++;
            end
        end
        expect_val("r5_tick_count", 32'(ticks), 32'd100);
        expect_val("r5_high_count", 32'(highs), 32'd300);
        expect_val("r5_tick_gaps", 32'(gap_err), 32'd0);

        // Ratio change while a period is in progress
        en = '0;
        step("idle");
        set_ratio(0, 6);
        en = 3'b001;
        step("chg");
        pat9[8] = pos_clk[0];
        step("chg");
        pat9[7] = pos_clk[0];
        set_ratio(0, 3);
        for (int i = 6; i >= 0; i--) begin
            step("chg");
            pat9[i] = pos_clk[0];
        end
        expect_val("ratio_change_pattern", 32'(pat9), 32'h000001C6);

        // Bypass with ratio 1, then ratio 2, then ratio 0
        en = '0;
        step("idle");
        set_ratio(0, 1);
        en = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step("byp1");
            expect_val("byp1_high_phase", 32'(pos_clk[0]), 32'd1);
            expect_val("byp1_low_phase", 32'(div_clk[0]), 32'd0);
            expect_val("byp1_tick", 32'(pos_tick[0]), 32'd1);
        end
        set_ratio(0, 2);
        for (int i = 3; i >= 0; i--) begin
            step("r2");
            pc4[i] = pos_clk[0];
            pt4[i] = pos_tick[0];
        end
        expect_val("r2_clk_pattern", 32'(pc4), 32'h0000000A);
        expect_val("r2_tick_pattern", 32'(pt4), 32'h0000000A);
        set_ratio(0, 0);
        for (int i = 0; i < 3; i++) begin
            step("byp0");
            expect_val("byp0_high_phase", 32'(pos_clk[0]), 32'd1);
            expect_val("byp0_low_phase", 32'(div_clk[0]), 32'd0);
            expect_val("byp0_tick", 32'(pos_tick[0]), 32'd1);
        end

        // Sync alignment of two out-of-phase channels, ch2 idle
        en = '0;
        step("idle");
        set_ratio(0, 4);
        set_ratio(1, 6);
        en = 3'b001;
        step("pre_sync");
        step("pre_sync");
        en = 3'b011;
        step("pre_sync");
        step("pre_sync");
        step("pre_sync");
        expect_val("out_of_phase", 32'(pos_tick[1:0]), 32'd1);
        sync = 1'b1;
        step("sync");
        sync = 1'b0;
        expect_val("sync_ticks", 32'(pos_tick), 32'd3);
        expect_val("sync_clks", 32'(pos_clk), 32'd3);
        step("post_sync");
        step("post_sync");
        step("post_sync");
        // ch0 is at the last cycle of its period: sync lands on its natural end.
        sync = 1'b1;
        step("sync_eop");
        sync = 1'b0;
        expect_val("sync_eop_ticks", 32'(pos_tick), 32'd3);
        step("post_sync");
        expect_val("sync_eop_single_tick", 32'(pos_tick), 32'd0);
        expect_val("idle_ch2_clk", 32'(div_clk[2]), 32'd0);
        // Sync together with an enable drop on ch0
        sync = 1'b1;
        en = 3'b010;
        step("sync_dis");
        sync = 1'b0;
        expect_val("sync_dis_ch0_clk", 32'(pos_clk[0]), 32'd0);
        expect_val("sync_dis_ticks", 32'(pos_tick), 32'd2);

        // Disable mid-high, then re-enable
        en = 3'b011;
        step("reen");
        step("reen");
        expect_val("before_dis_high", 32'(pos_clk[0]), 32'd1);
        en = 3'b010;
        step("dis");
        expect_val("dis_low", 32'(pos_clk[0]), 32'd0);
        en = 3'b011;
        step("reen");
        expect_val("reen_tick", 32'(pos_tick[0]), 32'd1);
        expect_val("reen_clk", 32'(pos_clk[0]), 32'd1);
        step("reen");

        // Asynchronous reset in the middle of a high phase
        expect_val("pre_rst_high", 32'(div_clk[0]), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        expect_val("async_rst_clk", 32'(div_clk), 32'd0);
        expect_val("async_rst_tick", 32'(div_tick), 32'd0);
        #1 rst = 1'b0;
        check_all("after_rst");

        // Randomized traffic
        en = '1;
        for (int c = 0; c < NC; c++) set_ratio(c, int'($urandom_range(0, 9)));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NC-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) set_ratio(int'($urandom_range(0, NC-1)), int'($urandom_range(0, 9)));
            sync = ($urandom_range(0, 24) == 0);
            step("rand");
        end
        sync = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
